// File: rtl/fir_xifu_pkg.sv
// fir_xifu_pkg: shared types and constants for the FIR XIFU coprocessor.
// Ports: none (package). Provides id2ctrl_t, sb_entry_t, ctrl2ex_t and default sizes.
// The XIF id width inside the structs is fixed by X_ID_WIDTH_DEFAULT.
package fir_xifu_pkg;

  localparam int unsigned NB_SLOTS_DEFAULT   = 4;
  localparam int unsigned X_ID_WIDTH_DEFAULT = 4;

  // Decode -> controller: one decoded, valid instruction per cycle.
  typedef struct packed {
    logic                          issue;
    logic [X_ID_WIDTH_DEFAULT-1:0] id;
  } id2ctrl_t;

  // One scoreboard slot.
  typedef struct packed {
    logic                          valid;
    logic [X_ID_WIDTH_DEFAULT-1:0] id;
    logic                          committed;
    logic                          killed;
  } sb_entry_t;

  // Controller -> execute: status of the oldest in-flight instruction.
  typedef struct packed {
    logic                          head_valid;
    logic [X_ID_WIDTH_DEFAULT-1:0] head_id;
    logic                          go;
    logic                          drop;
  } ctrl2ex_t;

endpackage

// File: rtl/fir_xifu_perf_cnt.sv
// fir_xifu_perf_cnt: 32-bit event counter with synchronous clear, wraps modulo 2^32.
// Latency: count visible the cycle after en_i. No backpressure.
// Ports: clk_i, rst_ni (async, active-low), clear_i, en_i, cnt_o.
module fir_xifu_perf_cnt (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        en_i,
  output logic [31:0] cnt_o
);

  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fir_xifu_ctrl.sv
// fir_xifu_ctrl: in-order scoreboard matching XIF commits to issued instructions; tells EX when
//   the head may write back (go) or must be discarded (drop). Flags are registered: issue/commit at t
//   are visible at t+1. ready_o = ex_ready_i & ~full, no retire->issue bypass while full.
// Ports: clk_i, rst_ni (async, active-low), clear_i (sync flush), id2ctrl_i, commit_valid_i/id_i/kill_i,
//   ex_ready_i, ready_o, ctrl2ex_o, retire_i, busy_o. Optional macro FIR_XIFU_CTRL_PERF_EN adds
//   perf_issued_o, perf_killed_o, perf_stall_o. X_ID_WIDTH must equal the package id width.
module fir_xifu_ctrl
  import fir_xifu_pkg::*;
#(
  parameter int unsigned NB_SLOTS   = NB_SLOTS_DEFAULT,
  parameter int unsigned X_ID_WIDTH = X_ID_WIDTH_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  id2ctrl_t              id2ctrl_i,
  input  logic                  commit_valid_i,
  input  logic [X_ID_WIDTH-1:0] commit_id_i,
  input  logic                  commit_kill_i,
  input  logic                  ex_ready_i,
  output logic                  ready_o,
  output ctrl2ex_t              ctrl2ex_o,
  input  logic                  retire_i,
  output logic                  busy_o
`ifdef FIR_XIFU_CTRL_PERF_EN
  ,
  output logic [31:0]           perf_issued_o,
  output logic [31:0]           perf_killed_o,
  output logic [31:0]           perf_stall_o
`endif
);

  localparam int unsigned PTR_W = $clog2(NB_SLOTS);
  localparam int unsigned CNT_W = PTR_W + 1;

  sb_entry_t        entries_q [NB_SLOTS];
  sb_entry_t        entries_d [NB_SLOTS];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] cm_ptr_q, cm_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  sb_entry_t head, cm_entry;
  logic      full, issue_fire, retire_fire;
  logic      head_go, head_drop;
  logic      commit_match, commit_bypass;

  assign full       = (count_q == CNT_W'(NB_SLOTS));
  assign ready_o    = ex_ready_i & ~full;
  assign issue_fire = id2ctrl_i.issue & ready_o;

  assign head      = entries_q[rd_ptr_q];
  assign head_go   = head.valid & head.committed & ~head.killed;
  assign head_drop = head.valid & head.committed &  head.killed;
  assign retire_fire = retire_i & (head_go | head_drop);

  // Commits arrive in program order, so only the oldest uncommitted entry can match.
  assign cm_entry     = entries_q[cm_ptr_q];
  assign commit_match = commit_valid_i & cm_entry.valid & ~cm_entry.committed
                      & (cm_entry.id == commit_id_i);
  // cm_ptr == wr_ptr with issue possible means every stored entry is already committed, so the
  // commit can only belong to the instruction being issued right now.
  assign commit_bypass = commit_valid_i & issue_fire & (cm_ptr_q == wr_ptr_q)
                       & (id2ctrl_i.id == commit_id_i);

  always_comb begin
    entries_d = entries_q;
    wr_ptr_d  = wr_ptr_q;
    cm_ptr_d  = cm_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q + CNT_W'(issue_fire) - CNT_W'(retire_fire);

    if (issue_fire) begin
      entries_d[wr_ptr_q].valid     = 1'b1;
      entries_d[wr_ptr_q].id        = id2ctrl_i.id;
      entries_d[wr_ptr_q].committed = commit_bypass;
      entries_d[wr_ptr_q].killed    = commit_bypass & commit_kill_i;
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    if (commit_match) begin
      entries_d[cm_ptr_q].committed = 1'b1;
      entries_d[cm_ptr_q].killed    = commit_kill_i;
    end
    if (commit_match | commit_bypass) begin
      cm_ptr_d = cm_ptr_q + PTR_W'(1);
    end

    if (retire_fire) begin
      entries_d[rd_ptr_q].valid = 1'b0;
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    if (clear_i) begin
      for (int i = 0; i < NB_SLOTS; i++) begin
        entries_d[i] = '0;
      end
      wr_ptr_d = '0;
      cm_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NB_SLOTS; i++) begin
        entries_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      cm_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      entries_q <= entries_d;
      wr_ptr_q  <= wr_ptr_d;
      cm_ptr_q  <= cm_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // head_id is masked so a retired slot's stale id never leaks to EX.
  always_comb begin
    ctrl2ex_o            = '0;
    ctrl2ex_o.head_valid = head.valid;
    ctrl2ex_o.head_id    = head.valid ? head.id : '0;
    ctrl2ex_o.go         = head_go;
    ctrl2ex_o.drop       = head_drop;
  end

  assign busy_o = (count_q != '0);

`ifndef SYNTHESIS
  // EX must only retire a head that is cleared to go or drop.
  retire_legal_a: assert property (@(posedge clk_i) disable iff (!rst_ni || clear_i)
    retire_i |-> (head_go | head_drop));
`endif

`ifdef FIR_XIFU_CTRL_PERF_EN
  fir_xifu_perf_cnt u_perf_issued (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear_i(clear_i),
    .en_i   (issue_fire),
    .cnt_o  (perf_issued_o)
  );

  fir_xifu_perf_cnt u_perf_killed (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear_i(clear_i),
    .en_i   (retire_fire & head_drop),
    .cnt_o  (perf_killed_o)
  );

  fir_xifu_perf_cnt u_perf_stall (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear_i(clear_i),
    .en_i   (id2ctrl_i.issue & ~ready_o),
    .cnt_o  (perf_stall_o)
  );
`endif

endmodule
